// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, memory and error signals of the data/fetch memory arbiter
interface dmem_arbiter_if #(parameter int width_p = 32);
  logic d_r_v_i, d_w_v_i, d_done_o, d_stall_o;
  logic [width_p-1:0] d_addr_i, d_data_i, d_data_o;
  logic f_r_v_i, f_done_o, f_stall_o;
  logic [width_p-1:0] f_addr_i, f_data_o;
  logic mem_r_v_o, mem_w_v_o, mem_ready_i, err_o;
  logic [width_p-1:0] mem_addr_o, mem_data_o, mem_data_i;
  modport slave (
    input d_r_v_i, d_w_v_i, d_addr_i, d_data_i, f_r_v_i, f_addr_i, mem_data_i, mem_ready_i,
    output d_data_o, d_done_o, d_stall_o, f_data_o, f_done_o, f_stall_o,
    output mem_r_v_o, mem_w_v_o, mem_addr_o, mem_data_o, err_o
  );
  modport master (
    output d_r_v_i, d_w_v_i, d_addr_i, d_data_i, f_r_v_i, f_addr_i, mem_data_i, mem_ready_i,
    input d_data_o, d_done_o, d_stall_o, f_data_o, f_done_o, f_stall_o,
    input mem_r_v_o, mem_w_v_o, mem_addr_o, mem_data_o, err_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one variable-latency memory between data and fetch ports
module dmem_arbiter #(
  parameter int width_p = 32,
  parameter int max_wait_p = 64,
  parameter int cnt_width_p = 7
) (
  input logic clk_i,
  input logic rst_i,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam logic [cnt_width_p-1:0] max_c = cnt_width_p'(max_wait_p);
  state_e state_q, state_d;
  // grant_q / last_q: 1 selects the fetch port
  logic grant_q, grant_d, last_q, last_d, we_q, we_d, err_q, err_d;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;
  logic [width_p-1:0] addr_q, addr_d, wdata_q, wdata_d, d_data_q, d_data_d, f_data_q, f_data_d;
  logic d_req, f_req, busy, done, timeout;
  assign d_req = bus.d_r_v_i | bus.d_w_v_i;
  assign f_req = bus.f_r_v_i;
  assign busy = state_q == BUSY;
  assign done = state_q == DONE;
  assign timeout = max_wait_p != 0 && cnt_q + cnt_width_p'(1) == max_c;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    we_d = we_q;
    err_d = err_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    d_data_d = d_data_q;
    f_data_d = f_data_q;
    case (state_q)
      IDLE: if (d_req || f_req) begin
        grant_d = d_req && f_req ? ~last_q : f_req;
        addr_d = grant_d ? bus.f_addr_i : bus.d_addr_i;
        wdata_d = bus.d_data_i;
        we_d = ~grant_d & bus.d_w_v_i;
        cnt_d = '0;
        err_d = 1'b0;
        state_d = BUSY;
      end
      BUSY: if (bus.mem_ready_i) begin
        d_data_d = grant_q || we_q ? d_data_q : bus.mem_data_i;
        f_data_d = grant_q && !we_q ? bus.mem_data_i : f_data_q;
        state_d = DONE;
      end else if (timeout) begin
        d_data_d = grant_q ? d_data_q : '0;
        f_data_d = grant_q ? '0 : f_data_q;
        err_d = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + cnt_width_p'(1);
      end
      DONE: begin
        last_d = grant_q;
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      we_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      d_data_q <= '0;
      f_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      we_q <= we_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      d_data_q <= d_data_d;
      f_data_q <= f_data_d;
    end
  assign bus.mem_r_v_o = busy & ~we_q;
  assign bus.mem_w_v_o = busy & we_q;
  assign bus.mem_addr_o = busy ? addr_q : '0;
  assign bus.mem_data_o = busy && we_q ? wdata_q : '0;
  assign bus.d_done_o = done & ~grant_q;
  assign bus.f_done_o = done & grant_q;
  assign bus.err_o = done & err_q;
  assign bus.d_data_o = d_data_q;
  assign bus.f_data_o = f_data_q;
  assign bus.d_stall_o = d_req & ~bus.d_done_o;
  assign bus.f_stall_o = f_req & ~bus.f_done_o;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-timestamp model of the arbiter (watchdog limit 4 BUSY cycles)
module tb_dmem_arbiter;
  logic clk = 0, rst = 0;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_d = 0, exp_f = 0;
  dmem_arbiter_if #(.width_p(32)) bus ();
  dmem_arbiter #(.width_p(32), .max_wait_p(4), .cnt_width_p(3)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.d_r_v_i = 0;
    bus.d_w_v_i = 0;
    bus.d_addr_i = 0;
    bus.d_data_i = 0;
    bus.f_r_v_i = 0;
    bus.f_addr_i = 0;
    bus.mem_ready_i = 0;
    bus.mem_data_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1;
    bus.d_r_v_i = 1;
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.mem_w_v_o, bus.d_done_o, bus.f_done_o, bus.err_o} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b, want 00000", {bus.mem_r_v_o, bus.mem_w_v_o, bus.d_done_o, bus.f_done_o, bus.err_o}); end
    n_cmp++; if ({bus.mem_addr_o, bus.mem_data_o, bus.d_data_o, bus.f_data_o} !== 128'b0) begin n_bad++; $display("FAIL reset_data: got %h, want 0", {bus.mem_addr_o, bus.mem_data_o, bus.d_data_o, bus.f_data_o}); end
    n_cmp++; if ({bus.d_stall_o, bus.f_stall_o} !== 2'b10) begin n_bad++; $display("FAIL reset_stall: got %b, want 10", {bus.d_stall_o, bus.f_stall_o}); end
    bus.d_r_v_i = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_d_read();
    @(negedge clk);
    bus.d_r_v_i = 1;
    bus.d_addr_i = 32'h100;
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.mem_w_v_o, bus.mem_addr_o} !== {2'b10, 32'h100}) begin n_bad++; $display("FAIL rd_strobe1: got %b %b %h, want 1 0 100", bus.mem_r_v_o, bus.mem_w_v_o, bus.mem_addr_o); end
    n_cmp++; if (bus.d_stall_o !== 1'b1) begin n_bad++; $display("FAIL rd_stall: got %b, want 1", bus.d_stall_o); end
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.d_done_o} !== 2'b10) begin n_bad++; $display("FAIL rd_strobe2: got %b, want 10", {bus.mem_r_v_o, bus.d_done_o}); end
    bus.mem_ready_i = 1;
    bus.mem_data_i = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if ({bus.d_done_o, bus.f_done_o, bus.mem_r_v_o, bus.err_o} !== 4'b1000) begin n_bad++; $display("FAIL rd_done: got %b, want 1000", {bus.d_done_o, bus.f_done_o, bus.mem_r_v_o, bus.err_o}); end
    n_cmp++; if (bus.d_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h, want deadbeef", bus.d_data_o); end
    n_cmp++; if (bus.d_stall_o !== 1'b0) begin n_bad++; $display("FAIL rd_stall_done: got %b, want 0", bus.d_stall_o); end
    exp_d = 32'hDEADBEEF;
    bus.d_r_v_i = 0;
    bus.mem_ready_i = 0;
    @(negedge clk);
    n_cmp++; if ({bus.d_done_o, bus.f_done_o, bus.d_data_o} !== {2'b00, exp_d}) begin n_bad++; $display("FAIL rd_hold: got %b %b %h, want 0 0 %h", bus.d_done_o, bus.f_done_o, bus.d_data_o, exp_d); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    rst = 1;
    #1 rst = 0;
    exp_d = 0;
    exp_f = 0;
    bus.d_w_v_i = 1;
    bus.d_addr_i = 32'h200;
    bus.d_data_i = 32'h55;
    bus.f_r_v_i = 1;
    bus.f_addr_i = 32'h40;
    @(negedge clk);
    n_cmp++; if ({bus.mem_w_v_o, bus.mem_r_v_o, bus.mem_addr_o, bus.mem_data_o} !== {2'b10, 32'h200, 32'h55}) begin n_bad++; $display("FAIL pri_dwrite: got %b%b %h %h, want 10 200 55", bus.mem_w_v_o, bus.mem_r_v_o, bus.mem_addr_o, bus.mem_data_o); end
    n_cmp++; if (bus.f_stall_o !== 1'b1) begin n_bad++; $display("FAIL pri_fstall1: got %b, want 1", bus.f_stall_o); end
    bus.mem_ready_i = 1;
    @(negedge clk);
    n_cmp++; if ({bus.d_done_o, bus.f_done_o, bus.f_stall_o} !== 3'b101) begin n_bad++; $display("FAIL pri_ddone: got %b, want 101", {bus.d_done_o, bus.f_done_o, bus.f_stall_o}); end
    bus.d_w_v_i = 0;
    bus.mem_ready_i = 0;
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.mem_w_v_o, bus.f_stall_o} !== 3'b001) begin n_bad++; $display("FAIL pri_idle: got %b, want 001", {bus.mem_r_v_o, bus.mem_w_v_o, bus.f_stall_o}); end
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.mem_addr_o} !== {1'b1, 32'h40}) begin n_bad++; $display("FAIL pri_fread: got %b %h, want 1 40", bus.mem_r_v_o, bus.mem_addr_o); end
    bus.mem_ready_i = 1;
    bus.mem_data_i = 32'h12345678;
    @(negedge clk);
    n_cmp++; if ({bus.f_done_o, bus.d_done_o, bus.f_stall_o, bus.f_data_o} !== {3'b100, 32'h12345678}) begin n_bad++; $display("FAIL pri_fdone: got %b%b%b %h, want 100 12345678", bus.f_done_o, bus.d_done_o, bus.f_stall_o, bus.f_data_o); end
    exp_f = 32'h12345678;
    bus.f_r_v_i = 0;
    bus.mem_ready_i = 0;
  endtask

  task automatic test_back_to_back();
    logic port;
    logic [31:0] rd = 0;
    bus.d_addr_i = 32'h600;
    bus.f_addr_i = 32'h700;
    bus.mem_ready_i = 1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      port = ((i / 3) % 2) == 1;
      if (i % 3 == 1) begin
        n_cmp++; if ({bus.mem_r_v_o, bus.mem_addr_o} !== {1'b1, port ? 32'h700 : 32'h600}) begin n_bad++; $display("FAIL b2b_grant %0d: got %b %h, want port %b", i, bus.mem_r_v_o, bus.mem_addr_o, port); end
      end
      if (i % 3 == 2) begin
        n_cmp++; if ({bus.d_done_o, bus.f_done_o} !== {~port, port}) begin n_bad++; $display("FAIL b2b_done %0d: got %b%b, want %b%b", i, bus.d_done_o, bus.f_done_o, ~port, port); end
        if (port) exp_f = rd; else exp_d = rd;
        n_cmp++; if ({bus.d_data_o, bus.f_data_o} !== {exp_d, exp_f}) begin n_bad++; $display("FAIL b2b_data %0d: got %h %h, want %h %h", i, bus.d_data_o, bus.f_data_o, exp_d, exp_f); end
      end else begin
        n_cmp++; if ({bus.d_done_o, bus.f_done_o} !== 2'b00) begin n_bad++; $display("FAIL b2b_pulse %0d: got %b%b, want 00", i, bus.d_done_o, bus.f_done_o); end
      end
      bus.d_r_v_i = i < 17;
      bus.f_r_v_i = i < 17;
      bus.mem_data_i = $urandom | 32'h1;
      if (i % 3 == 1) rd = bus.mem_data_i;
    end
    bus.mem_ready_i = 0;
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    bus.d_r_v_i = 1;
    bus.d_w_v_i = 1;
    bus.d_addr_i = 32'h400;
    bus.d_data_i = 32'hA5A5A5A5;
    @(negedge clk);
    n_cmp++; if ({bus.mem_w_v_o, bus.mem_r_v_o, bus.mem_addr_o, bus.mem_data_o} !== {2'b10, 32'h400, 32'hA5A5A5A5}) begin n_bad++; $display("FAIL rw_write: got %b%b %h %h, want 10 400 a5a5a5a5", bus.mem_w_v_o, bus.mem_r_v_o, bus.mem_addr_o, bus.mem_data_o); end
    bus.mem_ready_i = 1;
    bus.mem_data_i = 32'hFFFFFFFE;
    @(negedge clk);
    n_cmp++; if ({bus.d_done_o, bus.d_data_o} !== {1'b1, exp_d}) begin n_bad++; $display("FAIL rw_keep: got %b %h, want 1 %h", bus.d_done_o, bus.d_data_o, exp_d); end
    bus.d_r_v_i = 0;
    bus.d_w_v_i = 0;
    bus.mem_ready_i = 0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    bus.d_r_v_i = 1;
    bus.d_addr_i = 32'h300;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if ({bus.mem_r_v_o, bus.d_done_o, bus.err_o} !== 3'b100) begin n_bad++; $display("FAIL to_wait %0d: got %b, want 100", k, {bus.mem_r_v_o, bus.d_done_o, bus.err_o}); end
    end
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.d_done_o, bus.err_o, bus.d_data_o} !== {3'b011, 32'h0}) begin n_bad++; $display("FAIL to_abort: got %b %h, want 011 0", {bus.mem_r_v_o, bus.d_done_o, bus.err_o}, bus.d_data_o); end
    exp_d = 0;
    bus.d_r_v_i = 0;
    bus.f_r_v_i = 1;
    bus.f_addr_i = 32'h80;
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.d_done_o, bus.err_o} !== 3'b000) begin n_bad++; $display("FAIL to_idle: got %b, want 000", {bus.mem_r_v_o, bus.d_done_o, bus.err_o}); end
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.mem_addr_o} !== {1'b1, 32'h80}) begin n_bad++; $display("FAIL to_next: got %b %h, want 1 80", bus.mem_r_v_o, bus.mem_addr_o); end
    bus.mem_ready_i = 1;
    bus.mem_data_i = 32'h0BADF00D;
    @(negedge clk);
    n_cmp++; if ({bus.f_done_o, bus.err_o, bus.f_data_o} !== {2'b10, 32'h0BADF00D}) begin n_bad++; $display("FAIL to_next_done: got %b%b %h, want 10 0badf00d", bus.f_done_o, bus.err_o, bus.f_data_o); end
    exp_f = 32'h0BADF00D;
    bus.f_r_v_i = 0;
    bus.mem_ready_i = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.f_r_v_i = 1;
    bus.f_addr_i = 32'h500;
    @(negedge clk);
    n_cmp++; if (bus.mem_r_v_o !== 1'b1) begin n_bad++; $display("FAIL rm_busy: got %b, want 1", bus.mem_r_v_o); end
    rst = 1;
    #1;
    n_cmp++; if ({bus.mem_r_v_o, bus.mem_w_v_o} !== 2'b00) begin n_bad++; $display("FAIL rm_async: got %b, want 00", {bus.mem_r_v_o, bus.mem_w_v_o}); end
    @(negedge clk);
    n_cmp++; if ({bus.d_done_o, bus.f_done_o, bus.err_o, bus.mem_r_v_o, bus.d_data_o, bus.f_data_o} !== 68'b0) begin n_bad++; $display("FAIL rm_quiet: got %b %h %h, want 0", {bus.d_done_o, bus.f_done_o, bus.err_o, bus.mem_r_v_o}, bus.d_data_o, bus.f_data_o); end
    rst = 0;
    exp_d = 0;
    exp_f = 0;
    @(negedge clk);
    n_cmp++; if ({bus.mem_r_v_o, bus.mem_addr_o} !== {1'b1, 32'h500}) begin n_bad++; $display("FAIL rm_regrant: got %b %h, want 1 500", bus.mem_r_v_o, bus.mem_addr_o); end
    bus.mem_ready_i = 1;
    bus.mem_data_i = 32'h77;
    @(negedge clk);
    n_cmp++; if ({bus.f_done_o, bus.err_o, bus.f_data_o} !== {2'b10, 32'h77}) begin n_bad++; $display("FAIL rm_done: got %b%b %h, want 10 77", bus.f_done_o, bus.err_o, bus.f_data_o); end
    exp_f = 32'h77;
    bus.f_r_v_i = 0;
    bus.mem_ready_i = 0;
  endtask

  // Each access is modelled as timestamps: granted at cycle c, strobes c+1..s_end, done at s_end+1.
  task automatic test_random();
    int free_at = 0, s_start = 0, s_end = -1, done_c = -1, lat = 0, op;
    logic busy = 0, g = 0, we = 0, err = 0, last = 1, dp = 0, fp = 0, strobe, fin;
    logic [31:0] addr = 0, wd = 0, rd = 0, ed = exp_d, ef = exp_f;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      strobe = busy && c >= s_start && c <= s_end;
      fin = busy && c == done_c;
      if (fin && g && !we) ef = err ? 32'h0 : rd;
      if (fin && !g && !we) ed = err ? 32'h0 : rd;
      n_cmp++; if ({bus.mem_r_v_o, bus.mem_w_v_o} !== {strobe & ~we, strobe & we}) begin n_bad++; $display("FAIL rnd_strobe c%0d: got %b%b, want %b%b", c, bus.mem_r_v_o, bus.mem_w_v_o, strobe & ~we, strobe & we); end
      if (strobe) begin
        n_cmp++; if (bus.mem_addr_o !== addr || (we && bus.mem_data_o !== wd)) begin n_bad++; $display("FAIL rnd_bus c%0d: got %h %h, want %h %h", c, bus.mem_addr_o, bus.mem_data_o, addr, wd); end
      end
      n_cmp++; if ({bus.d_done_o, bus.f_done_o, bus.err_o} !== {fin & ~g, fin & g, fin & err}) begin n_bad++; $display("FAIL rnd_done c%0d: got %b, want %b", c, {bus.d_done_o, bus.f_done_o, bus.err_o}, {fin & ~g, fin & g, fin & err}); end
      n_cmp++; if ({bus.d_data_o, bus.f_data_o} !== {ed, ef}) begin n_bad++; $display("FAIL rnd_data c%0d: got %h %h, want %h %h", c, bus.d_data_o, bus.f_data_o, ed, ef); end
      if (fin) begin
        busy = 0;
        last = g;
        if (g) fp = 0; else dp = 0;
      end
      if (strobe && !err && c == s_start + lat) begin
        rd = $urandom;
        bus.mem_ready_i = 1;
        bus.mem_data_i = rd;
      end else begin
        bus.mem_ready_i = !strobe && $urandom_range(3) == 0;
        bus.mem_data_i = $urandom;
      end
      if (!dp) begin
        dp = c < 380 && $urandom_range(1) == 1;
        op = $urandom_range(2);
        bus.d_r_v_i = dp && op != 1;
        bus.d_w_v_i = dp && op != 0;
        bus.d_addr_i = $urandom;
        bus.d_data_i = $urandom;
      end
      if (!fp) begin
        fp = c < 380 && $urandom_range(1) == 1;
        bus.f_r_v_i = fp;
        bus.f_addr_i = $urandom;
      end
      #1;
      n_cmp++; if ({bus.d_stall_o, bus.f_stall_o} !== {dp & ~(fin & ~g), fp & ~(fin & g)}) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b%b, want %b%b", c, bus.d_stall_o, bus.f_stall_o, dp & ~(fin & ~g), fp & ~(fin & g)); end
      if (!busy && c >= free_at && (dp || fp)) begin
        g = dp && fp ? ~last : fp;
        we = !g && bus.d_w_v_i;
        addr = g ? bus.f_addr_i : bus.d_addr_i;
        wd = bus.d_data_i;
        lat = we ? $urandom_range(3) : $urandom_range(5);
        err = lat >= 4;
        s_start = c + 1;
        s_end = err ? c + 4 : c + 1 + lat;
        done_c = s_end + 1;
        free_at = done_c + 1;
        busy = 1;
      end
    end
    exp_d = ed;
    exp_f = ef;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_priority();
    test_back_to_back();
    test_rw_both();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the memory stage's data port (D) and the fetch stage's instruction port (F).
- Holds the granted request in registers and drives the memory until it completes.
- Returns read data with a one-cycle done pulse and gives each requester a stall signal.
- Ties are resolved round-robin; a watchdog aborts accesses that hang.

Parameters:
width_p, 32, data and address width in bits
max_wait_p, 64, maximum BUSY cycles before an access is aborted; 0 disables the watchdog
cnt_width_p, 7, width of the wait counter; must satisfy 2^cnt_width_p > max_wait_p

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
d_r_v_i  in  1  data read request, held until d_done_o
d_w_v_i  in  1  data write request, held until d_done_o
d_addr_i  in  width_p  data address
d_data_i  in  width_p  store data
d_data_o  out  width_p  load data, valid while d_done_o is high, held afterwards
d_done_o  out  1  one-cycle completion pulse for D
d_stall_o  out  1  D request pending and not done
f_r_v_i  in  1  fetch read request, held until f_done_o
f_addr_i  in  width_p  fetch address
f_data_o  out  width_p  fetched word, valid while f_done_o is high, held afterwards
f_done_o  out  1  one-cycle completion pulse for F
f_stall_o  out  1  F request pending and not done
mem_r_v_o  out  1  memory read strobe
mem_w_v_o  out  1  memory write strobe
mem_addr_o  out  width_p  memory address
mem_data_o  out  width_p  memory write data
mem_data_i  in  width_p  memory read data, valid when mem_ready_i is high
mem_ready_i  in  1  memory completes the current access
err_o  out  1  one-cycle pulse, aligned with done, when an access times out

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, last_grant=F (so D wins the first tie), wait counter=0, hold registers=0.
  - All outputs 0 except stalls, which are combinational.
- States and transitions:
  - IDLE -> BUSY: taken when any request is seen.
  - BUSY -> DONE: taken on mem_ready_i or on timeout.
  - DONE -> IDLE: always, after one cycle.
- IDLE:
  - d_req = d_r_v_i | d_w_v_i; f_req = f_r_v_i.
  - Only one request: grant that port.
  - Both requesting: grant the port that is not last_grant.
  - On grant, latch grant, addr, wdata and op. Write wins if d_r_v_i and d_w_v_i are both high.
  - Next state BUSY. mem_*_v_o stay 0 while in IDLE.
- BUSY:
  - mem_r_v_o / mem_w_v_o, mem_addr_o and mem_data_o are driven only from the hold registers. Requester inputs are ignored.
  - Strobes stay high every BUSY cycle until mem_ready_i.
  - On mem_ready_i: capture mem_data_i into the granted port's data register (reads only; writes leave it unchanged) and go to DONE.
  - Wait counter increments each BUSY cycle without ready.
  - If max_wait_p != 0 and the counter reaches max_wait_p: go to DONE with an error flag, load 0 into the data register, and drop the strobes.
- DONE:
  - Granted port's done_o=1 for exactly this cycle; err_o=1 if timed out.
  - Strobes are 0. last_grant <= grant. Wait counter cleared.
  - All requests are ignored this cycle, because requesters drop their request on the edge after done.
- Latency:
  - Request first high at cycle N with memory ready on its first BUSY cycle: strobe at N+1, done at N+2.
  - Minimum access period is 3 cycles.
- d_stall_o = d_req & ~d_done_o; f_stall_o = f_req & ~f_done_o. These are purely combinational.
- mem_ready_i outside BUSY is ignored.
- A requester deasserting mid-access does not abort the access; it completes and done still pulses.
- Reset mid-access forces IDLE immediately. There is no done pulse and no err pulse for the aborted access.
- d_data_o and f_data_o hold their last values until overwritten by a later read on the same port.

Test Plan:
- D read only, addr 0x100, mem_ready_i one cycle after the strobe, mem_data_i=0xDEADBEEF -> mem_r_v_o high at N+1 and N+2, d_done_o at N+3, d_data_o=0xDEADBEEF, f_done_o never high.
- D and F requesting together from reset, F addr 0x40, D write 0x55 to 0x200, 0-wait memory -> D write serviced first (mem_w_v_o, mem_data_o=0x55); F read strobe begins the cycle after IDLE returns; f_done_o follows; F stalled throughout.
- Both ports requesting continuously for 6 accesses -> grants alternate D,F,D,F,D,F; each done pulse lasts exactly 1 cycle.
- max_wait_p=4, mem_ready_i held 0 -> strobe high 4 cycles, then done and err_o pulse together, data=0, arbiter returns to IDLE and serves the next request.
- d_r_v_i and d_w_v_i both high -> write performed (mem_w_v_o=1, mem_r_v_o=0), d_data_o unchanged.
- rst_i asserted during BUSY -> strobes drop asynchronously, no done or err pulse; after release a held F request is granted normally.
